// File: rtl/sm510_pkg.sv
// Shared types and sizes for the SM510 data-RAM arbiter.
// SM510_RAM_ARB_CLEAR_EN selects whether the CLEAR state is used.
package sm510_pkg;

    localparam int RAM_ADDR_W = 7;
    localparam int RAM_DATA_W = 4;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    // First nibble of the display segment area in the data RAM.
    localparam logic [RAM_ADDR_W-1:0] DISP_RAM_BASE = 7'h60;

    typedef enum logic [1:0] {
        CLI_NONE,
        CLI_CPU,
        CLI_RTC,
        CLI_LCD
    } ram_client_t;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } arb_state_t;

endpackage

// File: rtl/sm510_ram_arb_if.sv
// Request/ack bundle between the three RAM clients and the arbiter.
// The busy signal is only driven high when SM510_RAM_ARB_CLEAR_EN is defined.
interface sm510_ram_arb_if;

    // Handshake: a client raises *_req with addr/we/wdata stable and holds
    // them until its *_ack pulses for one cycle; *_rdata is valid with that
    // pulse. The req is ignored in its own ack cycle.
    logic                               cpu_req;
    logic                               cpu_we;
    logic [sm510_pkg::RAM_ADDR_W-1:0]   cpu_addr;
    logic [sm510_pkg::RAM_DATA_W-1:0]   cpu_wdata;
    logic                               cpu_ack;
    logic [sm510_pkg::RAM_DATA_W-1:0]   cpu_rdata;

    logic                               rtc_req;
    logic                               rtc_we;
    logic [sm510_pkg::RAM_ADDR_W-1:0]   rtc_addr;
    logic [sm510_pkg::RAM_DATA_W-1:0]   rtc_wdata;
    logic                               rtc_ack;
    logic [sm510_pkg::RAM_DATA_W-1:0]   rtc_rdata;

    logic                               lcd_req;
    logic [sm510_pkg::RAM_ADDR_W-1:0]   lcd_addr;
    logic                               lcd_ack;
    logic [sm510_pkg::RAM_DATA_W-1:0]   lcd_rdata;

    logic                               busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output rtc_req, rtc_we, rtc_addr, rtc_wdata,
        input  rtc_ack, rtc_rdata,
        output lcd_req, lcd_addr,
        input  lcd_ack, lcd_rdata,
        input  busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  rtc_req, rtc_we, rtc_addr, rtc_wdata,
        output rtc_ack, rtc_rdata,
        input  lcd_req, lcd_addr,
        output lcd_ack, lcd_rdata,
        output busy
    );

endinterface

// File: rtl/sm510_arb_pick.sv
// Combinational grant selection: CPU first, then RTC, then LCD, except a
// starved LCD moves ahead of RTC (never ahead of CPU).
module sm510_arb_pick
    import sm510_pkg::*;
(
    input  logic        i_cpu_req,
    input  logic        i_rtc_req,
    input  logic        i_lcd_req,
    input  logic        i_lcd_starve,
    output ram_client_t o_grant
);

    always_comb begin
        o_grant = CLI_NONE;
        if (i_cpu_req)
            o_grant = CLI_CPU;
        else if (i_lcd_req && i_lcd_starve)
            o_grant = CLI_LCD;
        else if (i_rtc_req)
            o_grant = CLI_RTC;
        else if (i_lcd_req)
            o_grant = CLI_LCD;
    end

endmodule

// File: rtl/sm510_ram_arb.sv
// Single-port owner of the SM510 128x4 data RAM, shared by CPU, RTC and LCD.
// Define SM510_RAM_ARB_CLEAR_EN to zero the array after every rst (CLEAR state).
module sm510_ram_arb
    import sm510_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sm510_ram_arb_if.slave       bus,
    output arb_state_t           o_state,
    output logic [3:0]           o_lcd_wait
);

    localparam logic [3:0] L_STARVE = 4'(STARVE_MAX);
`ifdef SM510_RAM_ARB_CLEAR_EN
    localparam arb_state_t L_ENTRY = ST_CLEAR;
`else
    localparam arb_state_t L_ENTRY = ST_RUN;
`endif

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [RAM_DATA_W-1:0]  r_mem [RAM_DEPTH];
    logic                   r_cpu_ack, r_rtc_ack, r_lcd_ack;
    logic [RAM_DATA_W-1:0]  r_cpu_rdata, r_rtc_rdata, r_lcd_rdata;
    logic [3:0]             r_lcd_wait;
    logic                   w_cpu_m, w_rtc_m, w_lcd_m, w_starve;
    ram_client_t            w_pick, w_grant;
    logic                   w_mem_we, w_busy;
    logic [RAM_ADDR_W-1:0]  w_mem_addr;
    logic [RAM_DATA_W-1:0]  w_mem_wdata, w_mem_rdata;
`ifdef SM510_RAM_ARB_CLEAR_EN
    logic [RAM_ADDR_W-1:0]  r_clr_cnt;
`endif

    // A client in its ack cycle is masked so its held req is not served twice.
    assign w_cpu_m  = bus.cpu_req & ~r_cpu_ack;
    assign w_rtc_m  = bus.rtc_req & ~r_rtc_ack;
    assign w_lcd_m  = bus.lcd_req & ~r_lcd_ack;
    assign w_starve = (r_lcd_wait == L_STARVE);

    sm510_arb_pick u_pick (
        .i_cpu_req    (w_cpu_m),
        .i_rtc_req    (w_rtc_m),
        .i_lcd_req    (w_lcd_m),
        .i_lcd_starve (w_starve),
        .o_grant      (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= L_ENTRY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_RUN;
`ifdef SM510_RAM_ARB_CLEAR_EN
        if (r_state == ST_CLEAR && r_clr_cnt != 7'h7F)
            w_state_nxt = ST_CLEAR;
`endif
    end

    always_comb begin
        w_grant     = CLI_NONE;
        w_busy      = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (r_state)
            ST_RUN: begin
                w_grant = w_pick;
                case (w_pick)
                    CLI_CPU: begin
                        w_mem_we    = bus.cpu_we;
                        w_mem_addr  = bus.cpu_addr;
                        w_mem_wdata = bus.cpu_wdata;
                    end
                    CLI_RTC: begin
                        w_mem_we    = bus.rtc_we;
                        w_mem_addr  = bus.rtc_addr;
                        w_mem_wdata = bus.rtc_wdata;
                    end
                    CLI_LCD: w_mem_addr = bus.lcd_addr;
                    default: ;
                endcase
            end
            default: begin
`ifdef SM510_RAM_ARB_CLEAR_EN
                w_busy     = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt;
`endif
            end
        endcase
    end

`ifdef SM510_RAM_ARB_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_clr_cnt <= '0;
        else if (r_state == ST_CLEAR)
            r_clr_cnt <= r_clr_cnt + 7'd1;
    end
`endif

    // A write granted in a rst cycle is dropped along with its ack.
    assign w_mem_rdata = r_mem[w_mem_addr];
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we)
            r_mem[w_mem_addr] <= w_mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_ack   <= 1'b0;
            r_rtc_ack   <= 1'b0;
            r_lcd_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_rtc_rdata <= '0;
            r_lcd_rdata <= '0;
        end else begin
            r_cpu_ack <= (w_grant == CLI_CPU);
            r_rtc_ack <= (w_grant == CLI_RTC);
            r_lcd_ack <= (w_grant == CLI_LCD);
            if (w_grant == CLI_CPU) r_cpu_rdata <= w_mem_rdata;
            if (w_grant == CLI_RTC) r_rtc_rdata <= w_mem_rdata;
            if (w_grant == CLI_LCD) r_lcd_rdata <= w_mem_rdata;
        end
    end

    // lcd_wait counts unmasked, ungranted LCD cycles and holds in its ack cycle.
    always_ff @(posedge clk) begin
        if (rst)
            r_lcd_wait <= '0;
        else if (!bus.lcd_req || w_grant == CLI_LCD || r_state != ST_RUN)
            r_lcd_wait <= '0;
        else if (w_lcd_m && r_lcd_wait != L_STARVE)
            r_lcd_wait <= r_lcd_wait + 4'd1;
    end

    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.rtc_ack   = r_rtc_ack;
    assign bus.lcd_ack   = r_lcd_ack;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.rtc_rdata = r_rtc_rdata;
    assign bus.lcd_rdata = r_lcd_rdata;
    assign bus.busy      = w_busy;
    assign o_state       = r_state;
    assign o_lcd_wait    = r_lcd_wait;

endmodule

// File: tb/tb_sm510_ram_arb.sv
// Bench for sm510_ram_arb: directed table, corner sequences and random traffic
// against a cycle reference model; follows SM510_RAM_ARB_CLEAR_EN when defined.
module tb_sm510_ram_arb;
    import sm510_pkg::*;

    localparam int STARVE_MAX = 8;
`ifdef SM510_RAM_ARB_CLEAR_EN
    localparam int CLR_CYCLES = 128;
`else
    localparam int CLR_CYCLES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    arb_state_t dbg_state;
    logic [3:0] dbg_lcd_wait;

    sm510_ram_arb_if bus_if ();

    sm510_ram_arb #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .o_state    (dbg_state),
        .o_lcd_wait (dbg_lcd_wait)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: client 0=CPU, 1=RTC, 2=LCD.
    int m_mem [128];
    bit m_known [128];
    bit m_ack [3];
    int m_rd [3];
    bit m_rd_known [3];
    int m_wait;
    int m_clr_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int client_rank(input int c);
        if (c == 0) return 0;
        if (c == 1) return 2;
        return (m_wait == STARVE_MAX) ? 1 : 3;
    endfunction

    task automatic model_step();
        bit active [3];
        bit we [3];
        int addr [3];
        int wd [3];
        int best;
        int best_rank;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_ack[c] = 0; m_rd[c] = 0; m_rd_known[c] = 1;
            end
            m_wait = 0;
            m_clr_left = CLR_CYCLES;
            return;
        end
        if (m_clr_left > 0) begin
            m_mem[128 - m_clr_left] = 0;
            m_known[128 - m_clr_left] = 1;
            m_clr_left--;
            for (int c = 0; c < 3; c++) m_ack[c] = 0;
            m_wait = 0;
            return;
        end
        active[0] = bus_if.cpu_req && !m_ack[0];
        active[1] = bus_if.rtc_req && !m_ack[1];
        active[2] = bus_if.lcd_req && !m_ack[2];
        we[0] = bus_if.cpu_we; addr[0] = int'(bus_if.cpu_addr); wd[0] = int'(bus_if.cpu_wdata);
        we[1] = bus_if.rtc_we; addr[1] = int'(bus_if.rtc_addr); wd[1] = int'(bus_if.rtc_wdata);
        we[2] = 0;             addr[2] = int'(bus_if.lcd_addr); wd[2] = 0;
        best = -1;
        best_rank = 99;
        for (int c = 0; c < 3; c++)
            if (active[c] && client_rank(c) < best_rank) begin
                best = c;
                best_rank = client_rank(c);
            end
        if (!bus_if.lcd_req || best == 2) m_wait = 0;
        else if (active[2] && m_wait < STARVE_MAX) m_wait++;
        for (int c = 0; c < 3; c++) m_ack[c] = (best == c);
        if (best >= 0) begin
            m_rd[best] = m_mem[addr[best]];
            m_rd_known[best] = m_known[addr[best]];
            if (we[best]) begin
                m_mem[addr[best]] = wd[best];
                m_known[addr[best]] = 1;
            end
        end
    endtask

    // One clock: model the cycle, let the edge pass, then compare registered outputs.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("acks", {29'd0, bus_if.cpu_ack, bus_if.rtc_ack, bus_if.lcd_ack},
            {29'd0, m_ack[0], m_ack[1], m_ack[2]});
        chk("lcd_wait", {28'd0, dbg_lcd_wait}, m_wait);
        chk("busy", {31'd0, bus_if.busy}, {31'd0, m_clr_left > 0});
        if (m_rd_known[0]) chk("cpu_rdata", {28'd0, bus_if.cpu_rdata}, m_rd[0]);
        if (m_rd_known[1]) chk("rtc_rdata", {28'd0, bus_if.rtc_rdata}, m_rd[1]);
        if (m_rd_known[2]) chk("lcd_rdata", {28'd0, bus_if.lcd_rdata}, m_rd[2]);
    endtask

    function automatic logic get_ack(input int c);
        if (c == 0) return bus_if.cpu_ack;
        if (c == 1) return bus_if.rtc_ack;
        return bus_if.lcd_ack;
    endfunction

    function automatic logic [3:0] get_rd(input int c);
        if (c == 0) return bus_if.cpu_rdata;
        if (c == 1) return bus_if.rtc_rdata;
        return bus_if.lcd_rdata;
    endfunction

    task automatic drive(input int c, input logic req, input logic we,
                         input logic [6:0] addr, input logic [3:0] wd);
        if (c == 0) begin
            bus_if.cpu_req = req; bus_if.cpu_we = we; bus_if.cpu_addr = addr; bus_if.cpu_wdata = wd;
        end else if (c == 1) begin
            bus_if.rtc_req = req; bus_if.rtc_we = we; bus_if.rtc_addr = addr; bus_if.rtc_wdata = wd;
        end else begin
            bus_if.lcd_req = req; bus_if.lcd_addr = addr;
        end
    endtask

    task automatic single_access(input int c, input logic we, input logic [6:0] addr,
                                 input logic [3:0] wd, input logic [3:0] exp, input bit check_rd);
        drive(c, 1'b1, we, addr, wd);
        tick();
        chk("tbl_ack", {31'd0, get_ack(c)}, 32'd1);
        if (check_rd) chk("tbl_rdata", {28'd0, get_rd(c)}, {28'd0, exp});
        drive(c, 1'b0, 1'b0, 7'h0, 4'h0);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        int         client;
        logic       we;
        logic [6:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rd;
        bit         check_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int first_lcd;
        int max_wait;
        int busy_cnt;
        logic [3:0] rd_mid;

        tbl[0]  = '{0, 1'b1, 7'h12, 4'h3, 4'h0, 1'b0};
        tbl[1]  = '{0, 1'b1, 7'h12, 4'hA, 4'h3, 1'b1};
        tbl[2]  = '{0, 1'b0, 7'h12, 4'h0, 4'hA, 1'b1};
        tbl[3]  = '{1, 1'b1, 7'h60, 4'h7, 4'h0, 1'b0};
        tbl[4]  = '{1, 1'b0, 7'h60, 4'h0, 4'h7, 1'b1};
        tbl[5]  = '{2, 1'b0, 7'h60, 4'h0, 4'h7, 1'b1};
        tbl[6]  = '{0, 1'b1, 7'h7F, 4'hF, 4'h0, 1'b0};
        tbl[7]  = '{2, 1'b0, 7'h7F, 4'h0, 4'hF, 1'b1};
        tbl[8]  = '{1, 1'b1, 7'h00, 4'h9, 4'h0, 1'b0};
        tbl[9]  = '{0, 1'b0, 7'h00, 4'h0, 4'h9, 1'b1};
        tbl[10] = '{1, 1'b1, 7'h00, 4'h2, 4'h9, 1'b1};
        tbl[11] = '{2, 1'b0, 7'h00, 4'h0, 4'h2, 1'b1};

        for (int i = 0; i < 128; i++) begin m_mem[i] = 0; m_known[i] = 0; end
        for (int c = 0; c < 3; c++) drive(c, 1'b0, 1'b0, 7'h0, 4'h0);

        // Reset and (optionally) the power-on clear.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle(CLR_CYCLES + 2);

        for (int i = 0; i < 12; i++)
            single_access(tbl[i].client, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                          tbl[i].exp_rd, tbl[i].check_rd);

        // All three request together: acks arrive CPU, RTC, LCD on successive cycles.
        drive(0, 1'b1, 1'b0, 7'h12, 4'h0);
        drive(1, 1'b1, 1'b0, 7'h60, 4'h0);
        drive(2, 1'b1, 1'b0, 7'h7F, 4'h0);
        tick();
        chk("simul_n1", {29'd0, bus_if.cpu_ack, bus_if.rtc_ack, bus_if.lcd_ack}, 32'b100);
        drive(0, 1'b0, 1'b0, 7'h0, 4'h0);
        tick();
        chk("simul_n2", {29'd0, bus_if.cpu_ack, bus_if.rtc_ack, bus_if.lcd_ack}, 32'b010);
        drive(1, 1'b0, 1'b0, 7'h0, 4'h0);
        tick();
        chk("simul_n3", {29'd0, bus_if.cpu_ack, bus_if.rtc_ack, bus_if.lcd_ack}, 32'b001);
        drive(2, 1'b0, 1'b0, 7'h0, 4'h0);
        idle(2);

        // RTC held continuously with LCD held: LCD granted within STARVE_MAX+1 cycles.
        drive(1, 1'b1, 1'b0, 7'h01, 4'h0);
        drive(2, 1'b1, 1'b0, 7'h60, 4'h0);
        first_lcd = -1;
        for (int k = 0; k < 20 && first_lcd < 0; k++) begin
            tick();
            if (bus_if.lcd_ack) first_lcd = k;
        end
        chk("rtc_lcd_bound", {31'd0, first_lcd >= 0 && first_lcd <= STARVE_MAX}, 32'd1);
        chk("rtc_lcd_wait0", {28'd0, dbg_lcd_wait}, 32'd0);
        drive(1, 1'b0, 1'b0, 7'h0, 4'h0);
        drive(2, 1'b0, 1'b0, 7'h0, 4'h0);
        idle(2);

        // CPU and RTC both held: LCD starves up to STARVE_MAX, saturates, then wins.
        drive(0, 1'b1, 1'b0, 7'h12, 4'h0);
        drive(1, 1'b1, 1'b0, 7'h00, 4'h0);
        drive(2, 1'b1, 1'b0, 7'h7F, 4'h0);
        first_lcd = -1;
        max_wait = 0;
        for (int k = 0; k < 20 && first_lcd < 0; k++) begin
            tick();
            if (int'(dbg_lcd_wait) > max_wait) max_wait = int'(dbg_lcd_wait);
            if (bus_if.lcd_ack) first_lcd = k;
        end
        chk("starve_first", first_lcd, STARVE_MAX + 1);
        chk("starve_max", max_wait, STARVE_MAX);
        chk("starve_clear", {28'd0, dbg_lcd_wait}, 32'd0);
        for (int c = 0; c < 3; c++) drive(c, 1'b0, 1'b0, 7'h0, 4'h0);
        idle(2);

        // Random traffic on a small address window so accesses collide.
        for (int n = 0; n < 500; n++) begin
            if (bus_if.cpu_ack) bus_if.cpu_req = 1'b0;
            if (bus_if.rtc_ack) bus_if.rtc_req = 1'b0;
            if (bus_if.lcd_ack) bus_if.lcd_req = 1'b0;
            if (!bus_if.cpu_req && $urandom_range(0, 99) < 45)
                drive(0, 1'b1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (!bus_if.rtc_req && $urandom_range(0, 99) < 60)
                drive(1, 1'b1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (!bus_if.lcd_req && $urandom_range(0, 99) < 70)
                drive(2, 1'b1, 1'b0, 7'($urandom_range(0, 15)), 4'h0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            if (rst) for (int c = 0; c < 3; c++) drive(c, 1'b0, 1'b0, 7'h0, 4'h0);
            rst = 1'b0;
        end
        for (int c = 0; c < 3; c++) drive(c, 1'b0, 1'b0, 7'h0, 4'h0);
        idle(CLR_CYCLES + 2);

        // rst in the grant cycle of an RTC write: no ack, write dropped.
        drive(1, 1'b1, 1'b1, 7'h60, 4'h5);
        rst = 1'b1;
        tick();
        chk("mid_rst_ack", {31'd0, bus_if.rtc_ack}, 32'd0);
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 7'h0, 4'h0);
        idle(CLR_CYCLES + 2);
`ifdef SM510_RAM_ARB_CLEAR_EN
        rd_mid = 4'h0;
`else
        rd_mid = 4'h7;
`endif
        single_access(1, 1'b0, 7'h60, 4'h0, rd_mid, 1'b1);

`ifdef SM510_RAM_ARB_CLEAR_EN
        // Power-on clear: busy for exactly 128 cycles, then the array reads zero.
        single_access(0, 1'b1, 7'h7F, 4'hF, 4'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_cnt = bus_if.busy ? 1 : 0;
        for (int k = 0; k < 200 && bus_if.busy; k++) begin
            tick();
            if (bus_if.busy) busy_cnt++;
        end
        chk("clear_busy_len", busy_cnt, 128);
        single_access(0, 1'b0, 7'h7F, 4'h0, 4'h0, 1'b1);
`else
        busy_cnt = 0;
        chk("busy_tied_low", {31'd0, bus_if.busy}, busy_cnt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
